// File: rtl/mau_pkg.sv
// mau_pkg: shared encodings, state enum and alignment helper for mem_access_unit
package mau_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ALIGN   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RELEASE, S_RESP, S_ERR} state_t;
   // Reserved size is rejected the same way as a misaligned access.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
      return size == SZ_RSVD || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'b00);
   endfunction
endpackage

// File: rtl/mem_access_unit_load_extender.sv
// load_extender: combinational size/sign extension of right-justified load data
// Ports: data (raw captured word), size (SZ_* code), sgn (1 = sign-extend), ext (extended result)
module load_extender
   import mau_pkg::*;
#(
   parameter int DATA_W = 32
)(
   input  logic [DATA_W-1:0] data,
   input  logic [1:0]        size,
   input  logic              sgn,
   output logic [DATA_W-1:0] ext
);
   always_comb
      ext = size == SZ_BYTE ? {{(DATA_W-8){sgn & data[7]}}, data[7:0]}
          : size == SZ_HALF ? {{(DATA_W-16){sgn & data[15]}}, data[15:0]}
          : data;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-request load/store sequencer running the MFA/MFC handshake to RAM
// Ports: Clk/reset (async active-high); req_* request from control unit (valid/ready, rw, addr,
//   size, signed, wdata); resp_* one-cycle completion (valid, rdata, err); mem_* RAM side
//   (mfa, rw, addr, size, wdata out; rdata, mfc in).
// Optional: define MAU_TIMEOUT_EN to bound each MFC wait by TIMEOUT_CYCLES (resp_err=10).
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int ADDR_W         = 9,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
)(
   input  logic              Clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [1:0]        resp_err,
   output logic              mem_mfa,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_size,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_mfc
);
   state_t state, state_n;
   logic rw_q, sgn_q, accept, active, timed_out, to_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0] size_q;
   logic [DATA_W-1:0] wdata_q, rdata_q, ext, wmask;
   assign accept = req_valid && req_ready;
   assign active = state == S_ISSUE || state == S_RELEASE;
`ifdef MAU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt;
   logic hold;
   // Completion wins over a timeout that lands on the same cycle.
   assign timed_out = cnt == CNT_W'(TIMEOUT_CYCLES - 1) &&
                      ((state == S_ISSUE && !mem_mfc) || (state == S_RELEASE && mem_mfc));
   always_ff @(posedge Clk or posedge reset)
      if (reset) begin
         cnt  <= '0;
         to_q <= 1'b0;
         hold <= 1'b0;
      end else begin
         cnt  <= state_n != state ? '0 : cnt + 1'b1;
         to_q <= timed_out ? 1'b1 : accept ? 1'b0 : to_q;
         hold <= timed_out ? 1'b1 : hold && mem_mfc;
      end
   // A stuck-high MFC after a timeout must clear before the RAM sees a new request.
   assign req_ready = state == S_IDLE && !(hold && mem_mfc);
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT_CYCLES;
   assign timed_out = 1'b0;
   assign to_q      = 1'b0;
   assign req_ready = state == S_IDLE;
`endif
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:    if (accept) state_n = misaligned(req_size, req_addr[1:0]) ? S_ERR : S_ISSUE;
         S_ISSUE:   state_n = mem_mfc ? S_RELEASE : timed_out ? S_RESP : S_ISSUE;
         S_RELEASE: state_n = !mem_mfc || timed_out ? S_RESP : S_RELEASE;
         default:   state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge Clk or posedge reset)
      if (reset) state <= S_IDLE;
      else state <= state_n;
   always_ff @(posedge Clk or posedge reset)
      if (reset) begin
         rw_q    <= 1'b0;
         sgn_q   <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            rw_q    <= req_rw;
            sgn_q   <= req_signed;
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata;
         end
         // Only the first MFC-high cycle is captured; later RAM data is ignored.
         if (state == S_ISSUE && mem_mfc) rdata_q <= mem_rdata;
      end
   load_extender #(.DATA_W(DATA_W)) u_ext (.data(rdata_q), .size(size_q), .sgn(sgn_q), .ext(ext));
   assign wmask      = size_q == SZ_BYTE ? DATA_W'(8'hFF) : size_q == SZ_HALF ? DATA_W'(16'hFFFF) : '1;
   assign mem_mfa    = state == S_ISSUE;
   assign mem_rw     = active && rw_q;
   assign mem_addr   = active ? addr_q : '0;
   assign mem_size   = active ? size_q : '0;
   assign mem_wdata  = active ? wdata_q & wmask : '0;
   assign resp_valid = state == S_RESP || state == S_ERR;
   assign resp_err   = state == S_ERR ? ERR_ALIGN : (state == S_RESP && to_q) ? ERR_TIMEOUT : ERR_NONE;
   assign resp_rdata = (state == S_RESP && rw_q == RW_READ && !to_q) ? ext : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench with a reference model of the MFA/MFC sequencer
module tb_mem_access_unit;
   logic Clk = 1'b0, reset = 1'b1;
   logic req_valid, req_ready, req_rw, req_signed, resp_valid, mem_mfa, mem_rw, mem_mfc;
   logic [8:0] req_addr, mem_addr;
   logic [1:0] req_size, resp_err, mem_size;
   logic [31:0] req_wdata, resp_rdata, mem_wdata, mem_rdata;
   int total = 0, bad = 0;
   always #5 Clk = ~Clk;
   mem_access_unit dut (
      .Clk(Clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_mfa(mem_mfa),
      .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_size(mem_size), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_mfc(mem_mfc)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask
   function automatic logic [31:0] ext_model(input logic [31:0] rd, input logic [1:0] size, input logic sgn);
      longint v;
      if (size == 2) return rd;
      v = size == 0 ? longint'(rd % 256) : longint'(rd % 65536);
      if (sgn && v >= (size == 0 ? 128 : 32768)) v -= (size == 0 ? 256 : 65536);
      return 32'(v);
   endfunction
   function automatic logic [31:0] wd_model(input logic [31:0] wd, input logic [1:0] size);
      return size == 0 ? wd % 256 : size == 1 ? wd % 65536 : wd;
   endfunction
   // d1: MFA cycles before MFC rises; d2: cycles MFC stays high
   task automatic do_txn(input logic rw, input logic [8:0] addr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] wd, input logic [31:0] rd, input int d1, input int d2);
      logic is_bad;
      int k, m;
      is_bad = size == 3 || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
      check("accept_ready", 32'(req_ready), 1);
      req_valid = 1; req_rw = rw; req_addr = addr; req_size = size; req_signed = sgn; req_wdata = wd;
      tick();
      req_valid = 0;
      if (is_bad) begin
         check("err_valid", 32'(resp_valid), 1);
         check("err_code", 32'(resp_err), 1);
         check("err_rdata", resp_rdata, 0);
         check("err_mfa", 32'(mem_mfa), 0);
         req_valid = 1; req_addr = 9'($urandom);
         tick();
         req_valid = 0;
      end else begin
         k = 1 + d1;
         m = k + d2;
         for (int c = 1; c <= m + 1; c++) begin
            if (c > 1) tick();
            check("mfa", 32'(mem_mfa), 32'(c <= k));
            check("resp_valid", 32'(resp_valid), 32'(c == m + 1));
            check("busy_ready", 32'(req_ready), 0);
            if (c <= m) begin
               check("mem_addr", 32'(mem_addr), 32'(addr));
               check("mem_rw", 32'(mem_rw), 32'(rw));
               check("mem_size", 32'(mem_size), 32'(size));
               check("mem_wdata", mem_wdata, wd_model(wd, size));
            end
            if (c == m + 1) begin
               check("resp_rdata", resp_rdata, rw ? ext_model(rd, size, sgn) : 0);
               check("resp_err", 32'(resp_err), 0);
            end
            mem_mfc = c >= k && c < m;
            mem_rdata = c == k ? rd : $urandom;
            req_valid = c < m ? 1'($urandom) : 1'b0;
            req_rw = 1'($urandom); req_addr = 9'($urandom); req_size = 2'($urandom); req_wdata = $urandom;
         end
         tick();
      end
      check("idle_valid", 32'(resp_valid), 0);
      check("idle_ready", 32'(req_ready), 1);
      check("idle_mfa", 32'(mem_mfa), 0);
      check("idle_rdata", resp_rdata, 0);
      check("idle_err", 32'(resp_err), 0);
   endtask
   task automatic accept_read(input logic [8:0] a);
      req_valid = 1; req_rw = 1; req_addr = a; req_size = 2; req_signed = 0; req_wdata = 0;
      tick();
      req_valid = 0;
   endtask
   task automatic reset_mid();
      #2 reset = 1;
      #1;
      check("rst_mfa", 32'(mem_mfa), 0);
      check("rst_ready", 32'(req_ready), 1);
      check("rst_valid", 32'(resp_valid), 0);
      check("rst_addr", 32'(mem_addr), 0);
      #1 reset = 0;
      tick();
   endtask
   initial begin
      logic [8:0] a;
      req_valid = 0; req_rw = 0; req_addr = 0; req_size = 0; req_signed = 0; req_wdata = 0;
      mem_mfc = 0; mem_rdata = 0;
      repeat (2) @(posedge Clk);
      #1;
      check("reset_ready", 32'(req_ready), 1);
      check("reset_mfa", 32'(mem_mfa), 0);
      check("reset_valid", 32'(resp_valid), 0);
      check("reset_rdata", resp_rdata, 0);
      check("reset_err", 32'(resp_err), 0);
      check("reset_wdata", mem_wdata, 0);
      reset = 0;
      do_txn(1, 9'h010, 2, 0, 0, 32'hDEADBEEF, 2, 2);
      do_txn(1, 9'h031, 0, 1, 0, 32'h00000080, 0, 1);
      do_txn(1, 9'h031, 0, 0, 0, 32'h00000080, 1, 1);
      do_txn(1, 9'h032, 1, 1, 0, 32'h00008001, 0, 3);
      do_txn(0, 9'h022, 1, 0, 32'h12345678, 0, 1, 1);
      do_txn(0, 9'h023, 0, 0, 32'hCAFEF00D, 0, 3, 2);
      do_txn(1, 9'h013, 2, 0, 0, 32'h11111111, 0, 1);
      do_txn(0, 9'h040, 3, 0, 32'h55555555, 0, 0, 1);
      do_txn(1, 9'h021, 1, 1, 0, 32'h22222222, 0, 1);
      for (int i = 0; i < 300; i++) begin
         a = 9'($urandom);
         if ($urandom % 3 != 0) a[1:0] = 2'b00;
         do_txn(1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 5)), int'($urandom_range(1, 4)));
      end
`ifdef MAU_TIMEOUT_EN
      accept_read(9'h040);
      for (int c = 1; c <= 17; c++) begin
         if (c > 1) tick();
         check("to_mfa", 32'(mem_mfa), 32'(c <= 16));
         check("to_valid", 32'(resp_valid), 32'(c == 17));
      end
      check("to_err", 32'(resp_err), 2);
      check("to_rdata", resp_rdata, 0);
      tick();
      check("to_ready", 32'(req_ready), 1);
      accept_read(9'h044);
      for (int c = 1; c <= 18; c++) begin
         if (c > 1) tick();
         check("rel_to_valid", 32'(resp_valid), 32'(c == 18));
         mem_mfc = 1;
         mem_rdata = $urandom;
      end
      check("rel_to_err", 32'(resp_err), 2);
      check("rel_to_rdata", resp_rdata, 0);
      tick();
      check("hold_ready", 32'(req_ready), 0);
      mem_mfc = 0;
      #1;
      check("hold_release", 32'(req_ready), 1);
      tick();
      accept_read(9'h048);
      check("mid_mfa", 32'(mem_mfa), 1);
      reset_mid();
`else
      accept_read(9'h040);
      for (int c = 1; c <= 40; c++) begin
         check("hang_mfa", 32'(mem_mfa), 1);
         check("hang_valid", 32'(resp_valid), 0);
         tick();
      end
      reset_mid();
`endif
      do_txn(0, 9'h100, 2, 0, 32'hA5A5A5A5, 0, 0, 1);
      do_txn(1, 9'h104, 2, 0, 0, 32'h87654321, 1, 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
